// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types for the two-requester round-robin arbiter.
// State and grant encodings plus the burst counter sizing helper.
package mux_rr_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT_A = 2'd1,
    GNT_B = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_B = 1'b0,
    GRANT_A = 1'b1
  } grant_t;

  function automatic int cnt_width(input int max_burst);
    return (max_burst > 0) ? $clog2(max_burst + 1) : 1;
  endfunction

endpackage

// File: rtl/mux_rr_arbiter_two_input_mux.sv
// Shared 2:1 datapath mux; sel=1 selects a.
// Purely combinational.
module two_input_mux #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sel,
  output logic [WIDTH-1:0] out
);

  assign out = sel ? a : b;

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter granting A or B onto one shared datapath.
// Forwards the granted word with valid/ready and acks the requester.
module mux_rr_arbiter
  import mux_rr_arbiter_pkg::*;
#(
  parameter int WIDTH     = 32,
  parameter int MAX_BURST = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             a_req,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ack,
  input  logic             b_req,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ack,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  input  logic             out_ready,
  output logic             mux_sel
);

  localparam int      CW      = cnt_width(MAX_BURST);
  localparam int      LIM     = (MAX_BURST > 0) ? MAX_BURST - 1 : 0;
  localparam logic [CW-1:0] LAST = CW'(LIM);
  localparam bit      LIMITED = (MAX_BURST != 0);

  state_t          state;
  state_t          state_nxt;
  grant_t          last_grant;
  logic [CW-1:0]   burst_cnt;
  logic [CW-1:0]   burst_nxt;
  logic            gnt_a;
  logic            gnt_b;
  logic            transfer;
  logic            limit_hit;

  always_comb begin
    gnt_a     = (state == GNT_A);
    gnt_b     = (state == GNT_B);
    out_valid = (gnt_a & a_req) | (gnt_b & b_req);
    transfer  = out_valid & out_ready;
    a_ack     = gnt_a & transfer;
    b_ack     = gnt_b & transfer;
    limit_hit = LIMITED && transfer && (burst_cnt == LAST);
    state_nxt = state;
    burst_nxt = burst_cnt;
    unique case (state)
      IDLE: begin
        if (a_req && (!b_req || last_grant == GRANT_B))
          state_nxt = GNT_A;
        else if (b_req)
          state_nxt = GNT_B;
      end
      GNT_A: begin
        if (!a_req) begin
          state_nxt = b_req ? GNT_B : IDLE;
        end else if (limit_hit) begin
          // Limit reached: yield if B waits, else restart the burst.
          if (b_req) state_nxt = GNT_B;
          burst_nxt = '0;
        end else if (transfer && LIMITED) begin
          burst_nxt = burst_cnt + CW'(1);
        end
      end
      GNT_B: begin
        if (!b_req) begin
          state_nxt = a_req ? GNT_A : IDLE;
        end else if (limit_hit) begin
          if (a_req) state_nxt = GNT_A;
          burst_nxt = '0;
        end else if (transfer && LIMITED) begin
          burst_nxt = burst_cnt + CW'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      mux_sel    <= 1'b0;
      last_grant <= GRANT_B;
      burst_cnt  <= '0;
    end else begin
      state     <= state_nxt;
      burst_cnt <= burst_nxt;
      if (state_nxt == GNT_A && state != GNT_A) begin
        mux_sel    <= 1'b1;
        last_grant <= GRANT_A;
        burst_cnt  <= '0;
      end else if (state_nxt == GNT_B && state != GNT_B) begin
        mux_sel    <= 1'b0;
        last_grant <= GRANT_B;
        burst_cnt  <= '0;
      end
    end
  end

  two_input_mux #(
    .WIDTH(WIDTH)
  ) u_mux (
    .a  (a_data),
    .b  (b_data),
    .sel(mux_sel),
    .out(out_data)
  );

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: MAX_BURST=4 and MAX_BURST=0 instances.
// Inputs change 1ns after posedge; outputs sampled before the next edge.
module tb_mux_rr_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a_req = 1'b0;
  logic [31:0] a_data = '0;
  logic        b_req = 1'b0;
  logic [31:0] b_data = '0;
  logic        out_ready = 1'b0;

  logic        a_ack, b_ack, out_valid, mux_sel;
  logic [31:0] out_data;
  logic        a_ack0, b_ack0, out_valid0, mux_sel0;
  logic [31:0] out_data0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.WIDTH(32), .MAX_BURST(4)) dut (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_data(a_data), .a_ack(a_ack),
    .b_req(b_req), .b_data(b_data), .b_ack(b_ack),
    .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready), .mux_sel(mux_sel)
  );

  mux_rr_arbiter #(.WIDTH(32), .MAX_BURST(0)) dut0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_data(a_data), .a_ack(a_ack0),
    .b_req(b_req), .b_data(b_data), .b_ack(b_ack0),
    .out_valid(out_valid0), .out_data(out_data0),
    .out_ready(out_ready), .mux_sel(mux_sel0)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    a_req = 1'b0;
    b_req = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    #4;
    checks++;
    if (out_valid !== 1'b0 || a_ack !== 1'b0 || b_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs got v=%b aa=%b ba=%b want 0 0 0",
               out_valid, a_ack, b_ack);
    end
    checks++;
    if (mux_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_sel got %b want 0", mux_sel);
    end
    tick();
    rst = 1'b0;
    a_req = 1'b1;
    a_data = 32'h1111_2222;
    #3;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle_valid got %b want 0", out_valid);
    end
    tick();
    #3;
    checks++;
    if (out_valid !== 1'b1 || mux_sel !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_grant got v=%b sel=%b want 1 1",
               out_valid, mux_sel);
    end
    rst = 1'b1;
    out_ready = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || a_ack !== 1'b0 || mux_sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_async got v=%b aa=%b sel=%b want 0 0 0",
               out_valid, a_ack, mux_sel);
    end
    tick();
    tick();
    rst = 1'b0;
    b_req = 1'b1;
    #3;
    tick();
    #3;
    checks++;
    if (mux_sel !== 1'b1 || a_ack !== 1'b1 || b_ack !== 1'b0) begin
      errors++;
      $display("FAIL reset_tie_a got sel=%b aa=%b ba=%b want 1 1 0",
               mux_sel, a_ack, b_ack);
    end
  endtask

  task automatic test_single;
    do_reset();
    b_req = 1'b1;
    b_data = 32'hDEAD_BEEF;
    out_ready = 1'b1;
    #3;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_c1 got valid=%b want 0", out_valid);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      #3;
      checks++;
      if (out_valid !== 1'b1 || b_ack !== 1'b1 || a_ack !== 1'b0 ||
          mux_sel !== 1'b0 || out_data !== 32'hDEAD_BEEF) begin
        errors++;
        $display("FAIL single_%0d got v=%b ba=%b aa=%b sel=%b d=%h want 1 1 0 0 deadbeef",
                 i, out_valid, b_ack, a_ack, mux_sel, out_data);
      end
    end
  endtask

  task automatic test_rotation;
    logic ea;
    do_reset();
    a_req = 1'b1;
    b_req = 1'b1;
    a_data = 32'hA5A5_0001;
    b_data = 32'h5A5A_0002;
    out_ready = 1'b1;
    for (int i = 0; i < 17; i++) begin
      tick();
      #3;
      ea = ((i / 4) % 2) == 0;
      checks++;
      if (out_valid !== 1'b1 || a_ack !== ea || b_ack !== !ea ||
          mux_sel !== ea ||
          out_data !== (ea ? 32'hA5A5_0001 : 32'h5A5A_0002)) begin
        errors++;
        $display("FAIL rotate_%0d got v=%b aa=%b ba=%b sel=%b d=%h want a=%b",
                 i, out_valid, a_ack, b_ack, mux_sel, out_data, ea);
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    a_req = 1'b1;
    a_data = 32'h1234_5678;
    out_ready = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      #3;
      checks++;
      if (out_valid !== 1'b1 || a_ack !== 1'b0 ||
          out_data !== 32'h1234_5678 || dut.burst_cnt !== 3'd0) begin
        errors++;
        $display("FAIL bp_hold_%0d got v=%b aa=%b d=%h cnt=%0d want 1 0 12345678 0",
                 i, out_valid, a_ack, out_data, dut.burst_cnt);
      end
      tick();
    end
    out_ready = 1'b1;
    #3;
    checks++;
    if (a_ack !== 1'b1) begin
      errors++;
      $display("FAIL bp_ack got %b want 1", a_ack);
    end
    tick();
    a_req = 1'b0;
    #3;
    checks++;
    if (a_ack !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_single got aa=%b v=%b want 0 0", a_ack, out_valid);
    end
  endtask

  task automatic test_burst_wrap;
    do_reset();
    a_req = 1'b1;
    out_ready = 1'b1;
    tick();
    for (int i = 0; i < 9; i++) begin
      #3;
      checks++;
      if (a_ack !== 1'b1 || mux_sel !== 1'b1 ||
          dut.burst_cnt !== 3'(i % 4)) begin
        errors++;
        $display("FAIL wrap_%0d got aa=%b sel=%b cnt=%0d want 1 1 %0d",
                 i, a_ack, mux_sel, dut.burst_cnt, i % 4);
      end
      tick();
    end
    #3;
    checks++;
    if (dut.burst_cnt !== 3'd1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL wrap_end got cnt=%0d v=%b want 1 1",
               dut.burst_cnt, out_valid);
    end
  endtask

  task automatic test_unlimited;
    do_reset();
    a_req = 1'b1;
    b_req = 1'b1;
    a_data = 32'hCAFE_0A0A;
    b_data = 32'hF00D_0B0B;
    out_ready = 1'b1;
    for (int i = 0; i < 7; i++) begin
      tick();
      #3;
      checks++;
      if (a_ack0 !== 1'b1 || b_ack0 !== 1'b0 || mux_sel0 !== 1'b1 ||
          out_data0 !== 32'hCAFE_0A0A) begin
        errors++;
        $display("FAIL mb0_a_%0d got aa=%b ba=%b sel=%b d=%h want 1 0 1 cafe0a0a",
                 i, a_ack0, b_ack0, mux_sel0, out_data0);
      end
    end
    tick();
    a_req = 1'b0;
    #3;
    checks++;
    if (out_valid0 !== 1'b0 || b_ack0 !== 1'b0) begin
      errors++;
      $display("FAIL mb0_drop got v=%b ba=%b want 0 0", out_valid0, b_ack0);
    end
    tick();
    #3;
    checks++;
    if (b_ack0 !== 1'b1 || mux_sel0 !== 1'b0 ||
        out_data0 !== 32'hF00D_0B0B) begin
      errors++;
      $display("FAIL mb0_b got ba=%b sel=%b d=%h want 1 0 f00d0b0b",
               b_ack0, mux_sel0, out_data0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_rotation();
    test_backpressure();
    test_burst_wrap();
    test_unlimited();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
